// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (A - B - Bin) mod 2^WIDTH one bit per clock, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             dbit, bnext;

   // Single full-subtractor cell; operands shift right so bit 0 is always the current bit.
   always_comb begin
      dbit  = a_q[0] ^ b_q[0] ^ borrow_q;
      bnext = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      count_d  = count_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Bin;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            // Diff bits enter at the MSB and settle into place after WIDTH shifts.
            diff_d   = {dbit, diff_q[WIDTH-1:1]};
            borrow_d = bnext;
            count_d  = count_q + 1'b1;
            if (count_q == LastCnt) begin
               bout_d  = bnext;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         count_q  <= count_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign Diff      = diff_q;
   assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A, B;
   logic         Bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Diff;
   logic         Bout;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Bout      (Bout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, wait for DONE, check result, hold, then handshake.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] ed, input logic eb,
                        input int hold);
      int lat;
      lat = 0;
      check({tag, "_ready"}, in_ready, 1);
      A = a; B = b; Bin = bin; in_valid = 1'b1;
      @(posedge clk); #1;
      // Garbage on the operand inputs while busy must be ignored.
      A = ~a; B = ~b; Bin = ~bin;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, 0, 1);
         in_valid = 1'b0;
         return;
      end
      check({tag, "_lat"}, lat, W);
      check({tag, "_res"}, {Bout, Diff}, {eb, ed});
      check({tag, "_busy"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold"}, {in_ready, out_valid, Bout, Diff}, {1'b0, 1'b1, eb, ed});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
   endtask

   logic [8:0] q[$];
   logic [8:0] ent;
   logic [4:0] m;
   int         last_acc;
   int         nres;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Bin = 1'b0;
      #12;
      check("rst_state", {in_ready, out_valid, Bout, Diff}, {1'b1, 1'b0, 1'b0, 4'h0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("sub_9_3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 0);
      do_op("sub_3_5", 4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 0);
      do_op("sub_0_0_1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 0);
      do_op("sub_5_5_hold", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 3);

      // Reset in the second RUN cycle aborts the operation.
      A = 4'd12; B = 4'd7; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("abort_out", {in_ready, out_valid, Bout, Diff}, {1'b1, 1'b0, 1'b0, 4'h0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) check("abort_noresult", out_valid, 0);
      end
      do_op("sub_12_7_1", 4'd12, 4'd7, 1'b1, 4'd4, 1'b0, 0);

      // Back-to-back stream with both handshakes held high.
      in_valid = 1'b1; out_ready = 1'b1; last_acc = -1; nres = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (cyc >= 40) in_valid = 1'b0;
         A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
         #3;
         if (in_valid && in_ready) begin
            q.push_back({Bin, B, A});
            if (last_acc >= 0) check("stream_gap", cyc - last_acc, W + 2);
            last_acc = cyc;
         end
         @(posedge clk); #1;
         if (out_valid) begin
            if (q.size() == 0) begin
               check("stream_extra", 1, 0);
            end else begin
               ent = q.pop_front();
               m = {1'b0, ent[3:0]} - {1'b0, ent[7:4]} - {4'b0, ent[8]};
               check("stream_res", {Bout, Diff}, m);
               nres++;
            end
         end
      end
      check("stream_count", nres, 7);
      out_ready = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               m = 5'(a) - 5'(b) - 5'(c);
               do_op("exh", W'(a), W'(b), 1'(c), m[3:0], m[4], 0);
            end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands present on A/B/Bin.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port A, input, WIDTH bits: minuend, unsigned.
REQ-007 The block SHALL have port B, input, WIDTH bits: subtrahend, unsigned.
REQ-008 The block SHALL have port Bin, input, 1 bit: initial borrow-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Diff/Bout hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port Diff, output, WIDTH bits: difference.
REQ-012 The block SHALL have port Bout, output, 1 bit: final borrow-out.

Function
REQ-013 The block SHALL compute Diff = (A - B - Bin) mod 2^WIDTH and Bout = 1 iff A < B + Bin (unsigned, WIDTH+1-bit compare).
REQ-014 The block SHALL compute bit-serially, LSB first, with one full-subtractor cell and a 1-bit borrow register, one bit per clk cycle.
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 The block SHALL assert in_ready only in IDLE.
REQ-017 The block SHALL accept on an edge with in_valid && in_ready: register A, B, Bin into internal registers, clear bit counter to 0, go to RUN.
REQ-018 In RUN, each edge SHALL process bit[count] using the borrow register (initialised to Bin), store the diff bit, update the borrow, and increment count.
REQ-019 The edge processing bit WIDTH-1 SHALL move the FSM to DONE, loading Bout from the final borrow.
REQ-020 out_valid SHALL be high exactly in DONE; latency SHALL be WIDTH cycles from the accept edge to out_valid high.
REQ-021 In DONE, Diff and Bout SHALL be held stable until the edge with out_valid && out_ready, which returns the FSM to IDLE.
REQ-022 The block SHALL NOT accept new operands on the same edge as the output handshake; peak throughput is one operation per WIDTH+2 cycles.
REQ-023 Changes on A, B, Bin, in_valid during RUN or DONE SHALL have no effect.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 Diff/Bout values outside DONE are don't-care except after reset.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, Diff=0, Bout=0, count=0, borrow=0, regardless of state.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result emitted; after release the first accept SHALL behave as from power-up.

Verification
REQ-028 A=9, B=3, Bin=0, WIDTH=4 -> Diff=6, Bout=0, out_valid high 4 cycles after the accept edge.
REQ-029 A=3, B=5, Bin=0 -> Diff=4'hE, Bout=1; A=0, B=0, Bin=1 -> Diff=4'hF, Bout=1 (wrap-around).
REQ-030 A=5, B=5, Bin=0 with out_ready held low 3 cycles in DONE -> Diff=0, Bout=0 held stable, out_valid=1, in_ready=0 throughout; IDLE one edge after out_ready rises.
REQ-031 rst_n pulsed low during the 2nd RUN cycle of A=12, B=7 -> out_valid=0, Diff=0, Bout=0, in_ready=1 immediately; then A=12, B=7, Bin=1 -> Diff=4, Bout=0.
REQ-032 in_valid and out_ready held high continuously, A/B/Bin changed every cycle -> one accept per 6 cycles, each result matching the operands sampled at its accept edge.
REQ-033 Exhaustive random check, all 512 A/B/Bin combinations at WIDTH=4 -> Diff and Bout match REQ-013 for every operation.
